// File: rtl/combinator_pkg.sv
// combinator_pkg: shared types and constants for the pixel combinator.
//   state_t      - frame FSM states (IDLE, REQ, OUT)
//   IDLE_COORD   - coordinate broadcast while idle; deliberately not all-ones,
//                  because all-ones marks an empty queue
//   BLANK_COLOUR - colour emitted for a pixel that no queue supplied in time
//   MISSED_W     - width of the saturating missed-pixel counter
package combinator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [31:0] IDLE_COORD   = 32'h7FFF_FFFF;
  localparam int          BLANK_COLOUR = 0;
  localparam int          MISSED_W     = 16;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: x/y position within a frame, plus position flags.
//   clk, reset    - clock and synchronous active-high reset
//   clear         - restart at (0,0) at the beginning of a frame
//   advance       - move to the next pixel in raster order
//   x, y          - current pixel coordinate
//   sof, eol, last- first pixel of frame / last pixel of line / last of frame
module raster_counter #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  sof,
  output logic                  eol,
  output logic                  last
);

  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(IMG_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(IMG_HEIGHT - 1);

  assign sof  = (x == '0) && (y == '0);
  assign eol  = (x == X_LAST);
  assign last = eol && (y == Y_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last) begin
        // Frame complete: park at the origin for the next frame.
        x <= '0;
        y <= '0;
      end else if (eol) begin
        x <= '0;
        y <= y + DATA_WIDTH'(1);
      end else begin
        x <= x + DATA_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_combinator.sv
// pixel_combinator: assembles one frame of pixels from NUM_QUEUES pixel queues.
// For each raster position it broadcasts the coordinate, waits up to TIMEOUT
// cycles for a queue to report a hit, then presents the pixel on a
// valid/ready output stream.
//   clk, reset                 - clock, synchronous active-high reset
//   start_i                    - begin one frame (ignored while busy)
//   xpixel_check/ypixel_check  - requested coordinate to all queues
//   hit_i, colour_i            - per-queue hit flag and colour
//   pixel_o, pixel_valid_o,
//   pixel_ready_i              - output pixel stream
//   sof_o, eol_o               - start-of-frame / end-of-line qualifiers
//   frame_done_o, multi_hit_o  - one-cycle event pulses
//   busy_o                     - frame in progress
//   missed_count_o             - saturating count of timed-out pixels
module pixel_combinator
  import combinator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RBG_SIZE   = 24,
  parameter int NUM_QUEUES = 4,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int TIMEOUT    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  input  logic [NUM_QUEUES-1:0]          hit_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [RBG_SIZE-1:0]            pixel_o,
  output logic                           pixel_valid_o,
  input  logic                           pixel_ready_i,
  output logic                           sof_o,
  output logic                           eol_o,
  output logic                           frame_done_o,
  output logic                           busy_o,
  output logic                           multi_hit_o,
  output logic [MISSED_W-1:0]            missed_count_o
);

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t                state;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0] x_cur;
  logic [DATA_WIDTH-1:0] y_cur;
  logic                  at_sof;
  logic                  at_eol;
  logic                  at_last;
  logic [RBG_SIZE-1:0]   hit_colour;
  logic                  any_hit;
  logic                  multi_hit;
  logic                  frame_start;
  logic                  pixel_accept;

  assign frame_start  = (state == IDLE) && start_i;
  assign pixel_accept = (state == OUT) && pixel_ready_i;

  raster_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (frame_start),
    .advance (pixel_accept),
    .x       (x_cur),
    .y       (y_cur),
    .sof     (at_sof),
    .eol     (at_eol),
    .last    (at_last)
  );

  // The coordinate is derived only from registered state, so queues see a
  // glitch-free request that changes exactly on the REQ entry edge.
  assign xpixel_check = (state == IDLE) ? DATA_WIDTH'(IDLE_COORD) : x_cur;
  assign ypixel_check = (state == IDLE) ? DATA_WIDTH'(IDLE_COORD) : y_cur;

  assign any_hit = |hit_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hit = (hit_i & (hit_i - NUM_QUEUES'(1))) != '0;

  // Lowest-index queue wins: scan downward so lower indices overwrite.
  // NOTE: a default assignment before any conditional keeps this block
  // purely combinational (no latch on the no-hit path).
  always_comb begin
    hit_colour = RBG_SIZE'(BLANK_COLOUR);
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      if (hit_i[k]) hit_colour = colour_i[k*RBG_SIZE +: RBG_SIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      pixel_o        <= '0;
      pixel_valid_o  <= 1'b0;
      sof_o          <= 1'b0;
      eol_o          <= 1'b0;
      frame_done_o   <= 1'b0;
      busy_o         <= 1'b0;
      multi_hit_o    <= 1'b0;
      missed_count_o <= '0;
    end else begin
      frame_done_o <= 1'b0;
      multi_hit_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (start_i) begin
            state          <= REQ;
            busy_o         <= 1'b1;
            wait_cnt       <= '0;
            missed_count_o <= '0;
          end
        end

        REQ: begin
          if (any_hit) begin
            // A hit on the final wait cycle still wins over the timeout.
            pixel_o       <= hit_colour;
            multi_hit_o   <= multi_hit;
            pixel_valid_o <= 1'b1;
            sof_o         <= at_sof;
            eol_o         <= at_eol;
            state         <= OUT;
          end else if (wait_cnt == WAIT_LAST) begin
            pixel_o       <= RBG_SIZE'(BLANK_COLOUR);
            pixel_valid_o <= 1'b1;
            sof_o         <= at_sof;
            eol_o         <= at_eol;
            state         <= OUT;
            if (missed_count_o != '1) missed_count_o <= missed_count_o + MISSED_W'(1);
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        OUT: begin
          // pixel_o/sof_o/eol_o are untouched here, so they hold under backpressure.
          if (pixel_ready_i) begin
            pixel_valid_o <= 1'b0;
            sof_o         <= 1'b0;
            eol_o         <= 1'b0;
            wait_cnt      <= '0;
            if (at_last) begin
              state        <= IDLE;
              busy_o       <= 1'b0;
              frame_done_o <= 1'b1;
            end else begin
              state <= REQ;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_combinator.sv
// tb_pixel_combinator: randomized self-checking bench for pixel_combinator.
// A queue responder answers coordinate requests from a per-pixel plan
// (hit delay, single/multi hit, colours) and drives random junk on hit_i
// whenever no request is pending. The reference model is simply the list of
// expected output pixels derived from that plan.
module tb_pixel_combinator;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 2;
  localparam int NQ      = 2;
  localparam int TMO     = 8;
  localparam int DW      = 32;
  localparam int CW      = 24;
  localparam int NPIX    = IMG_W * IMG_H;
  localparam logic [31:0] IDLE_C = 32'h7FFF_FFFF;

  logic              clk = 1'b0;
  logic              reset;
  logic              start_i;
  logic [DW-1:0]     xpixel_check, ypixel_check;
  logic [NQ-1:0]     hit_i;
  logic [NQ*CW-1:0]  colour_i;
  logic [CW-1:0]     pixel_o;
  logic              pixel_valid_o, pixel_ready_i;
  logic              sof_o, eol_o, frame_done_o, busy_o, multi_hit_o;
  logic [15:0]       missed_count_o;

  pixel_combinator #(
    .DATA_WIDTH (DW), .RBG_SIZE (CW), .NUM_QUEUES (NQ),
    .IMG_WIDTH (IMG_W), .IMG_HEIGHT (IMG_H), .TIMEOUT (TMO)
  ) dut (
    .clk (clk), .reset (reset), .start_i (start_i),
    .xpixel_check (xpixel_check), .ypixel_check (ypixel_check),
    .hit_i (hit_i), .colour_i (colour_i),
    .pixel_o (pixel_o), .pixel_valid_o (pixel_valid_o), .pixel_ready_i (pixel_ready_i),
    .sof_o (sof_o), .eol_o (eol_o), .frame_done_o (frame_done_o),
    .busy_o (busy_o), .multi_hit_o (multi_hit_o), .missed_count_o (missed_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Per-pixel plan and derived expectations.
  int          delay   [NPIX];  // REQ cycle on which the queue answers; >=TMO means never
  bit          multi   [NPIX];
  bit          hit_bit [NPIX];
  logic [CW-1:0] col_a [NPIX];  // colour of the winning queue
  logic [CW-1:0] col_b [NPIX];  // colour of the other queue
  logic [CW-1:0] exp_col [NPIX];
  int          exp_miss, exp_multi;

  // Live stimulus / monitor state.
  bit   rand_ready;
  int   hold_idx, hold_left;
  int   wcnt;
  int   exp_idx, run, done_cnt, multi_cnt;
  int   vcyc [NPIX];
  int   cyc = 0;
  int   start_cyc, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Queue responder and sink.
  always @(posedge clk) begin
    int idx;
    #1;
    idx = int'(ypixel_check) * IMG_W + int'(xpixel_check);
    if (busy_o === 1'b1 && pixel_valid_o === 1'b0 && idx >= 0 && idx < NPIX) begin
      if (delay[idx] == wcnt) begin
        if (multi[idx]) begin
          hit_i = 2'b11; colour_i = {col_b[idx], col_a[idx]};
        end else if (hit_bit[idx]) begin
          hit_i = 2'b10; colour_i = {col_a[idx], col_b[idx]};
        end else begin
          hit_i = 2'b01; colour_i = {col_b[idx], col_a[idx]};
        end
      end else begin
        hit_i = '0;
        colour_i = {CW'($urandom), CW'($urandom)};
      end
      wcnt++;
    end else begin
      wcnt = 0;
      hit_i = NQ'($urandom);
      colour_i = {CW'($urandom), CW'($urandom)};
    end

    if (pixel_valid_o === 1'b1 && idx == hold_idx && hold_left > 0) begin
      pixel_ready_i = 1'b0;
      hold_left--;
    end else begin
      pixel_ready_i = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Output monitor against the expected pixel list.
  always @(negedge clk) begin
    if (pixel_valid_o === 1'b1) begin
      run++;
      if (exp_idx < NPIX) begin
        check("pix_sof_eol", {pixel_o, sof_o, eol_o},
              {exp_col[exp_idx], exp_idx == 0, (exp_idx % IMG_W) == IMG_W - 1});
        check("coord", {xpixel_check, ypixel_check},
              {32'(exp_idx % IMG_W), 32'(exp_idx / IMG_W)});
        if (pixel_ready_i) begin
          vcyc[exp_idx] = run;
          run = 0;
          exp_idx++;
        end
      end else begin
        check("pix_overrun", exp_idx, NPIX - 1);
      end
    end
    if (frame_done_o === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (multi_hit_o === 1'b1) multi_cnt++;
  end

  task automatic plan_clean();
    for (int i = 0; i < NPIX; i++) begin
      delay[i]   = 0;
      multi[i]   = 1'b0;
      hit_bit[i] = 1'($urandom);
      col_a[i]   = CW'(16 * (i / IMG_W) + (i % IMG_W));
      col_b[i]   = CW'($urandom);
    end
  endtask

  task automatic plan_random();
    for (int i = 0; i < NPIX; i++) begin
      delay[i]   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 2))
                                              : int'($urandom_range(0, 2));
      multi[i]   = (delay[i] < TMO) && ($urandom_range(0, 3) == 0);
      hit_bit[i] = 1'($urandom);
      col_a[i]   = CW'($urandom);
      col_b[i]   = CW'($urandom);
    end
  endtask

  task automatic begin_frame(input bit rr, input int hold);
    exp_miss = 0;
    exp_multi = 0;
    for (int i = 0; i < NPIX; i++) begin
      exp_col[i] = (delay[i] >= TMO) ? '0 : col_a[i];
      if (delay[i] >= TMO) exp_miss++;
      else if (multi[i]) exp_multi++;
      vcyc[i] = 0;
    end
    rand_ready = rr;
    hold_idx = hold;
    hold_left = 5;
    exp_idx = 0; run = 0; done_cnt = 0; multi_cnt = 0; done_cyc = 0;
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_frame(input int pulse_at, input bit timed, input int hold);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk); n++;
      if (n == pulse_at) begin
        start_i = 1'b1;
        @(negedge clk); n++;
        start_i = 1'b0;
      end
    end
    check("frame_done_seen", done_cnt > 0, 1'b1);
    if (timed) check("done_latency", done_cyc - start_cyc, 16);
    repeat (4) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("pix_count", exp_idx, NPIX);
    check("missed", missed_count_o, exp_miss);
    check("multi_pulses", multi_cnt, exp_multi);
    check("busy_after", busy_o, 1'b0);
    check("xcheck_idle", xpixel_check, IDLE_C);
    if (hold >= 0) check("hold_cycles", vcyc[hold], 6);
  endtask

  initial begin
    int n;
    reset = 1'b1; start_i = 1'b0; hit_i = '0; colour_i = '0; pixel_ready_i = 1'b1;
    rand_ready = 1'b0; hold_idx = -1; hold_left = 0; wcnt = 0;
    exp_idx = 0; run = 0; done_cnt = 0; multi_cnt = 0;
    plan_clean();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pixel", pixel_o, 0);
    check("rst_valid", pixel_valid_o, 0);
    check("rst_sof_eol", {sof_o, eol_o}, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_multi", multi_hit_o, 0);
    check("rst_missed", missed_count_o, 0);
    check("rst_coords", {xpixel_check, ypixel_check}, {IDLE_C, IDLE_C});
    @(posedge clk); #1 reset = 1'b0;

    // Clean frame: colour 0x10*y+x, hit on first REQ cycle, ready high.
    plan_clean();
    begin_frame(1'b0, -1);
    finish_frame(-1, 1'b1, -1);

    // Backpressure on pixel (2,0) plus a multi-hit on pixel (0,1).
    plan_clean();
    multi[4] = 1'b1; col_a[4] = 24'hAAAAAA; col_b[4] = 24'hBBBBBB;
    begin_frame(1'b0, 2);
    finish_frame(-1, 1'b0, 2);

    // Timeout on (1,1); hit on the final wait cycle for (2,1).
    plan_clean();
    delay[5] = TMO;
    delay[6] = TMO - 1;
    begin_frame(1'b0, -1);
    finish_frame(-1, 1'b0, -1);

    // Start pulsed while busy: frame unaffected, missed count not cleared.
    plan_clean();
    delay[1] = TMO + 1;
    begin_frame(1'b0, -1);
    finish_frame(14, 1'b0, -1);

    // Reset while pixel (3,0) is being output.
    plan_clean();
    begin_frame(1'b0, -1);
    n = 0;
    while (!(pixel_valid_o === 1'b1 && xpixel_check == 3) && n < 100) begin
      @(negedge clk); n++;
    end
    check("reach_pixel3", n < 100, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_valid", pixel_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_coords", {xpixel_check, ypixel_check}, {IDLE_C, IDLE_C});
    check("abort_no_done", done_cnt, 0);
    plan_clean();
    begin_frame(1'b0, -1);
    finish_frame(-1, 1'b1, -1);

    // Randomized frames with random backpressure.
    for (int f = 0; f < 6; f++) begin
      plan_random();
      begin_frame(1'b1, -1);
      finish_frame(-1, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_combinator.md
PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, coordinate width.
- RBG_SIZE, 24, colour width.
- NUM_QUEUES, 4, number of pixel queues served.
- IMG_WIDTH, 640, pixels per line.
- IMG_HEIGHT, 480, lines per frame.
- TIMEOUT, 16, maximum wait cycles per pixel.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-high.
- start_i, in, 1, begin one frame.
- xpixel_check, out, DATA_WIDTH, requested x, broadcast to all queues.
- ypixel_check, out, DATA_WIDTH, requested y, broadcast to all queues.
- hit_i, in, NUM_QUEUES, queue k front matched the requested coordinate; registered one cycle after the match.
- colour_i, in, NUM_QUEUES*RBG_SIZE, queue k colour, valid with hit_i[k].
- pixel_o, out, RBG_SIZE, output pixel colour.
- pixel_valid_o, out, 1, pixel_o valid.
- pixel_ready_i, in, 1, sink accepts.
- sof_o, out, 1, qualifies the first pixel of the frame.
- eol_o, out, 1, qualifies the last pixel of a line.
- frame_done_o, out, 1, one-cycle pulse.
- busy_o, out, 1, frame in progress.
- multi_hit_o, out, 1, one-cycle pulse.
- missed_count_o, out, 16, saturating count of timed-out pixels.

Function
REQ-003 FSM states SHALL be IDLE, REQ and OUT.
REQ-004 IDLE: on start_i, x and y SHALL be set to 0 and the FSM SHALL go to REQ; otherwise it SHALL stay in IDLE.
REQ-005 In IDLE, xpixel_check and ypixel_check SHALL both equal IDLE_COORD (0x7FFF_FFFF); never all-ones, because all-ones is the queue empty marker.
REQ-006 In REQ and OUT, xpixel_check and ypixel_check SHALL equal the registered current x and y.
REQ-007 On REQ entry, wait_cnt SHALL be 0.
REQ-008 In REQ with any hit_i bit set, the block SHALL capture colour_i of the lowest-index asserted bit and go to OUT on the next cycle.
REQ-009 If more than one hit_i bit is set in that cycle, multi_hit_o SHALL pulse.
REQ-010 In REQ with no hit and wait_cnt == TIMEOUT-1, the block SHALL capture BLANK_COLOUR (0), increment missed_count_o (saturating at 0xFFFF) and go to OUT; with no hit and a lower wait_cnt, it SHALL increment wait_cnt. A hit on the final wait cycle SHALL take priority over timeout.
REQ-011 hit_i SHALL be ignored outside REQ.
REQ-012 OUT: pixel_valid_o SHALL be 1, and pixel_o, sof_o and eol_o SHALL be held stable until pixel_ready_i is 1.
REQ-013 sof_o SHALL be 1 iff x==0 and y==0; eol_o SHALL be 1 iff x==IMG_WIDTH-1.
REQ-014 On OUT with ready and not the last pixel: x SHALL increment; at x==IMG_WIDTH-1, x SHALL wrap to 0 and y SHALL increment; the FSM SHALL then go to REQ.
REQ-015 On OUT with ready at x==IMG_WIDTH-1 and y==IMG_HEIGHT-1: frame_done_o SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-016 Minimum throughput SHALL be one pixel per 2 cycles (hit in first REQ cycle, ready already high).
REQ-017 start_i SHALL be ignored while busy_o is 1; busy_o SHALL be 1 in REQ and OUT.
REQ-018 missed_count_o SHALL clear on start_i accepted in IDLE.

Reset
REQ-019 reset SHALL take priority over all inputs, including mid-frame, and SHALL return the FSM to IDLE.
REQ-020 Reset values SHALL be: x=0, y=0, wait_cnt=0, pixel_o=0, pixel_valid_o=0, sof_o=0, eol_o=0, frame_done_o=0, busy_o=0, multi_hit_o=0, missed_count_o=0, check coordinates=IDLE_COORD.

Structure
REQ-021 combinator_pkg SHALL hold the FSM state enum, IDLE_COORD, BLANK_COLOUR and the missed-counter width.
REQ-022 One sub-module, raster_counter (x/y advance, wrap, sof/eol/last flags), SHALL be instantiated.

Verification
Bench parameters: IMG_WIDTH=4, IMG_HEIGHT=2, NUM_QUEUES=2, TIMEOUT=8.
REQ-023 Clean frame:
- Stimulus: start; queue model hits every coordinate on the first REQ cycle with colour = 0x10*y + x; ready tied high.
- Response: 8 pixels 0x00,0x01,0x02,0x03,0x10..0x13; sof on pixel 0; eol on pixels 3 and 7; frame_done 16 cycles after start.
REQ-024 Backpressure:
- Stimulus: ready low for 5 cycles on pixel (2,0).
- Response: pixel_o=0x02 held with valid for 6 cycles; check coordinates stay (2,0); no extra hit consumed.
REQ-025 Timeout:
- Stimulus: no hit for (1,1).
- Response: after 8 REQ cycles, pixel 0x000000 is output; missed_count_o=1.
- Stimulus: hit arriving on wait cycle 7.
- Response: real colour is output, not blank.
REQ-026 Multi-hit:
- Stimulus: hit_i=2'b11, colour_i={0xBBBBBB,0xAAAAAA}.
- Response: pixel 0xAAAAAA; multi_hit_o pulses once.
REQ-027 Reset mid-frame:
- Stimulus: reset during pixel (3,0) OUT.
- Response: next cycle valid=0, busy=0, coordinates=0x7FFF_FFFF; a new start restarts at (0,0) with sof.
REQ-028 Start while busy:
- Stimulus: start_i pulsed mid-frame.
- Response: no effect on coordinates; exactly one frame_done.
